// File: rtl/gcd_unit_if.sv
// rtl/gcd_unit_if.sv - start/operand/result bundle for gcd_unit
interface gcd_unit_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 2 * WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic             err;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start, a_in, b_in,
        input  busy, done, gcd_out, err, iter_count
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, gcd_out, err, iter_count
    );
endinterface

// File: rtl/gcd_unit.sv
// rtl/gcd_unit.sv - iterative GCD engine; GCD_BINARY_EN selects Stein steps instead of plain subtraction
module gcd_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 2 * WIDTH
) (
    input logic       clk,
    input logic       reset_n,
    gcd_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] gcd_q;
    logic             err_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

`ifdef GCD_BINARY_EN
    localparam int K_W = $clog2(WIDTH) + 1;
    logic [K_W-1:0] k;
`endif

    // Step counter sticks at all-ones so very long runs never appear short
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Busy depends only on the state, so it rises the cycle after acceptance
    assign bus.busy       = (state == TEST) || (state == DONE);
    assign bus.done       = done_q;
    assign bus.gcd_out    = gcd_q;
    assign bus.err        = err_q;
    assign bus.iter_count = cnt_q;

    // Control FSM with all outputs registered; done is set on the edge entering DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            gcd_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
`ifdef GCD_BINARY_EN
            k      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x     <= bus.a_in;
                        y     <= bus.b_in;
                        cnt_q <= '0;
                        err_q <= 1'b0;
`ifdef GCD_BINARY_EN
                        k     <= '0;
`endif
                        // A zero operand needs no iteration: gcd(a,0) = a
                        if (bus.a_in == '0 || bus.b_in == '0) begin
                            gcd_q  <= bus.a_in | bus.b_in;
                            err_q  <= (bus.a_in == '0) && (bus.b_in == '0);
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= TEST;
                        end
                    end
                end
                TEST: begin
`ifdef GCD_BINARY_EN
                    if (x == y) begin
                        gcd_q  <= x << k;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (!x[0] && !y[0]) begin
                        x     <= x >> 1;
                        y     <= y >> 1;
                        k     <= k + 1'b1;
                        cnt_q <= cnt_inc;
                    end else if (!x[0]) begin
                        x     <= x >> 1;
                        cnt_q <= cnt_inc;
                    end else if (!y[0]) begin
                        y     <= y >> 1;
                        cnt_q <= cnt_inc;
                    end else if (x > y) begin
                        x     <= x - y;
                        cnt_q <= cnt_inc;
                    end else begin
                        y     <= y - x;
                        cnt_q <= cnt_inc;
                    end
`else
                    if (x == y) begin
                        gcd_q  <= x;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (x > y) begin
                        x     <= x - y;
                        cnt_q <= cnt_inc;
                    end else begin
                        y     <= y - x;
                        cnt_q <= cnt_inc;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_unit.sv
// tb/tb_gcd_unit.sv - scoreboard bench for gcd_unit
module tb_gcd_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;

    typedef struct {
        logic [WIDTH-1:0] g;
        logic             e;
        logic [CNT_W-1:0] it;
        int               lat;
        int               acc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q[$];
    exp_t mon_e;

    gcd_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gcd_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned b);
        exp_t        r;
        int unsigned x;
        int unsigned y;
        int unsigned n;
        int unsigned sh;
        x  = a;
        y  = b;
        n  = 0;
        sh = 0;
        r.acc = 0;
        if (a == 0 || b == 0) begin
            r.g   = WIDTH'(a | b);
            r.e   = (a == 0 && b == 0);
            r.it  = '0;
            r.lat = 1;
            return r;
        end
        while (x != y) begin
`ifdef GCD_BINARY_EN
            if (x % 2 == 0 && y % 2 == 0) begin
                x = x / 2; y = y / 2; sh++;
            end else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0) y = y / 2;
            else if (x > y) x = x - y;
            else y = y - x;
`else
            if (x > y) x = x - y;
            else y = y - x;
`endif
            n++;
        end
        r.g   = WIDTH'(x << sh);
        r.e   = 1'b0;
        r.it  = CNT_W'(n);
        r.lat = int'(n) + 2;
        return r;
    endfunction

    // Every done pulse must match the oldest outstanding expectation, including its cycle
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("gcd_out", bus.gcd_out, mon_e.g);
                check("err", bus.err, mon_e.e);
                check("iter_count", bus.iter_count, mon_e.it);
                check("latency", cyc - mon_e.acc + 1, mon_e.lat);
                check("busy_with_done", bus.busy, 1);
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic run_op(input int unsigned a, input int unsigned b);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while ((bus.busy || bus.done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        e     = model(a, b);
        e.acc = cyc + 1;
        q.push_back(e);
        bus.a_in  = WIDTH'(a);
        bus.b_in  = WIDTH'(b);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drain(70000);
        repeat (2) @(negedge clk);
        check("hold_gcd", bus.gcd_out, e.g);
        check("idle_busy", bus.busy, 0);
    endtask

    task automatic held_start(input int unsigned a, input int unsigned b);
        exp_t e;
        int   per;
        @(negedge clk);
        e   = model(a, b);
        per = e.lat + 1;
        for (int i = 0; i < 3; i++) begin
            e.acc = cyc + 1 + i * per;
            q.push_back(e);
        end
        bus.a_in  = WIDTH'(a);
        bus.b_in  = WIDTH'(b);
        bus.start = 1'b1;
        repeat (2 * per + 1) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drain(200);
        repeat (3 * per) @(negedge clk);
    endtask

    task automatic reset_abort();
        @(negedge clk);
        bus.a_in  = 16'd1000;
        bus.b_in  = 16'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_gcd_out", bus.gcd_out, 0);
        check("rst_err", bus.err, 0);
        check("rst_done", bus.done, 0);
        check("rst_iter", bus.iter_count, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=%0d expected=%0d", cyc, 0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #2;
        check("init_gcd_out", bus.gcd_out, 0);
        check("init_err", bus.err, 0);
        check("init_done", bus.done, 0);
        check("init_iter", bus.iter_count, 0);
        check("init_busy", bus.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(12, 18);
        run_op(0, 35);
        run_op(0, 0);
        run_op(35, 0);
        run_op(17, 17);
        run_op(1, 65535);
        held_start(21, 14);
        reset_abort();
        run_op(9, 6);
        for (int i = 0; i < 6; i++) begin
            run_op($urandom_range(1, 400), $urandom_range(1, 400));
        end
        run_op(65535, 65535);
        run_op(48, 180);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 2*WIDTH: width of the iteration counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a computation; sampled only in IDLE.
REQ-006 a_in  input  WIDTH  first operand, unsigned; captured when start is accepted.
REQ-007 b_in  input  WIDTH  second operand, unsigned; captured when start is accepted.
REQ-008 busy  output  1  high from the cycle after acceptance until done is asserted, inclusive.
REQ-009 done  output  1  single-cycle pulse; the result is valid.
REQ-010 gcd_out  output  WIDTH  registered result; held until the next accepted start.
REQ-011 err  output  1  high with done when both operands were zero; held with gcd_out.
REQ-012 iter_count  output  CNT_W  number of TEST-state steps taken by the last computation; held with gcd_out.

Function
REQ-013 The FSM SHALL have states IDLE, TEST and DONE only.
REQ-014 In IDLE with start=1, the block SHALL capture a_in into x, capture b_in into y, clear iter_count and err, and go to TEST at that edge.
REQ-015 In IDLE with start=1 and a_in=0 or b_in=0, the block SHALL go directly to DONE instead of TEST, with gcd_out = a_in|b_in and err = (a_in==0 && b_in==0).
REQ-016 In TEST with x==y, the block SHALL load gcd_out with the result and go to DONE.
REQ-017 In TEST with x>y, the block SHALL set x <= x-y, increment iter_count, and stay in TEST.
REQ-018 In TEST with x<y, the block SHALL set y <= y-x, increment iter_count, and stay in TEST.
REQ-019 All subtraction is unsigned at WIDTH bits; the larger operand is always the minuend, so no underflow occurs.
REQ-020 In DONE, the block SHALL assert done=1 for exactly one cycle and return to IDLE at the next edge.
REQ-021 Latency: done SHALL be high in cycle S+2 after the accepting edge, where S is the final iter_count; for zero operands, done is high in cycle 1.
REQ-022 A start asserted while busy=1 or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 A start asserted in the same cycle done is high SHALL be ignored, because the state is not IDLE; the next start is accepted in IDLE.
REQ-024 iter_count SHALL saturate at all-ones rather than wrap.
REQ-025 busy SHALL be a function of state only: busy = (state==TEST) || (state==DONE).

Reset
REQ-026 When reset_n=0, the block SHALL immediately force state=IDLE, x=0, y=0, gcd_out=0, err=0, done=0 and iter_count=0, independent of clk.
REQ-027 A reset asserted mid-computation SHALL abort it, and no done pulse SHALL follow.
REQ-028 After reset_n rises, the first start SHALL be accepted on the first rising clk edge on which start=1.

Configuration
REQ-029 Macro GCD_BINARY_EN: when defined, TEST SHALL use binary (Stein) steps, with a shift register k of width clog2(WIDTH)+1 that is cleared on acceptance.
REQ-030 With GCD_BINARY_EN, TEST priority SHALL be, each step incrementing iter_count:
- x==y: result = x<<k
- x and y both even: x>>=1, y>>=1, k++
- x even: x>>=1
- y even: y>>=1
- otherwise: subtract as in REQ-017/REQ-018.
REQ-031 Without GCD_BINARY_EN, k and its logic SHALL be absent, and TEST follows REQ-016 to REQ-018 exactly.

Verification
REQ-032 Reset, then a=12, b=18, start pulse -> default build: done in cycle 4, gcd_out=6, iter_count=2, err=0; binary build: gcd_out=6, iter_count=4.
REQ-033 a=0, b=35 -> done in cycle 1, gcd_out=35, err=0, iter_count=0; a=0, b=0 -> gcd_out=0, err=1.
REQ-034 a=17, b=17 -> done in cycle 2, gcd_out=17, iter_count=0; a=1, b=65535 (WIDTH=16), default build -> gcd_out=1, iter_count=65534.
REQ-035 Start held high continuously with a=21, b=14 -> exactly one done per computation with gcd_out=7; no start accepted while busy or in the done cycle.
REQ-036 a=1000, b=3, reset_n pulsed low in cycle 5 -> all outputs 0 immediately, no done pulse; a subsequent a=9, b=6 -> gcd_out=3.
